// File: rtl/mem_responder_if.sv
// Streaming read/write handshake between the accelerator wrapper (master)
// and the host-side memory agent mem_responder (slave).
interface mem_responder_if;
  logic        read_enable;
  logic [63:0] read_addr;
  logic        finish_read;
  logic [63:0] read_ready;
  logic [31:0] read_data;
  logic        write_enable;
  logic [63:0] write_addr;
  logic [31:0] write_data;
  logic        finish_write;
  logic [63:0] write_ready;

  modport master (
    output read_enable, read_addr, finish_read,
    output write_enable, write_addr, write_data, finish_write,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_enable, read_addr, finish_read,
    input  write_enable, write_addr, write_data, finish_write,
    output read_ready, read_data, write_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Host-side memory agent: one-outstanding read/write handshake FSM over a word
// array, plus backdoor port and access counters. MEM_RESP_RANDLAT_EN adds LFSR latency jitter.
module mem_responder #(
  parameter int          AW       = 13,
  parameter int          RD_LAT   = 2,
  parameter int          WR_LAT   = 1,
  parameter logic [31:0] OOR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_addr,
  input  logic [31:0]   bd_wdata,
  output logic [31:0]   bd_rdata,
  output logic          bd_err,
  output logic          busy,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count,
  output logic [15:0]   oor_count
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RLAT,
    S_RRDY,
    S_RACK,
    S_WLAT,
    S_WRDY,
    S_WACK
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   lat_cnt_q, lat_cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          oor_q, oor_d;
  logic [31:0]   rd_count_q, rd_count_d;
  logic [31:0]   wr_count_q, wr_count_d;
  logic [15:0]   oor_count_q, oor_count_d;
  logic [31:0]   read_data_q;
  logic [31:0]   bd_rdata_q;
  logic          bd_err_q;

  logic          rd_load;
  logic          oor_hit;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic [31:0]   mem [DEPTH];

  // Word index and range check straight off the byte addresses.
  logic [AW-1:0] rd_idx, wr_idx;
  logic          rd_oor, wr_oor;
  logic          unused_addr_lsbs;

  assign rd_idx           = bus.read_addr[AW+1:2];
  assign wr_idx           = bus.write_addr[AW+1:2];
  assign rd_oor           = |bus.read_addr[63:AW+2];
  assign wr_oor           = |bus.write_addr[63:AW+2];
  assign unused_addr_lsbs = ^{bus.read_addr[1:0], bus.write_addr[1:0]};

  logic [15:0] lat_extra;
  logic [15:0] rd_lat_init, wr_lat_init;

`ifdef MEM_RESP_RANDLAT_EN
  logic [15:0] lfsr_q;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, free-running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign lat_extra = {13'd0, lfsr_q[2:0]};
`else
  assign lat_extra = 16'd0;
`endif

  assign rd_lat_init = 16'(RD_LAT - 1) + lat_extra;
  assign wr_lat_init = 16'(WR_LAT - 1) + lat_extra;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latches are inferred.
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    idx_d       = idx_q;
    oor_d       = oor_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    oor_count_d = oor_count_q;
    rd_load     = 1'b0;
    oor_hit     = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = bd_addr;
    mem_wdata   = bd_wdata;

    case (state_q)
      S_IDLE: begin
        mem_we = bd_we;
        if (bus.read_enable) begin
          state_d   = S_RLAT;
          idx_d     = rd_idx;
          oor_d     = rd_oor;
          lat_cnt_d = rd_lat_init;
        end else if (bus.write_enable) begin
          state_d   = S_WLAT;
          idx_d     = wr_idx;
          oor_d     = wr_oor;
          lat_cnt_d = wr_lat_init;
        end
      end

      S_RLAT: begin
        if (!bus.read_enable) begin
          state_d = S_IDLE;
        end else if (lat_cnt_q == 16'd0) begin
          state_d = S_RRDY;
          rd_load = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 16'd1;
        end
      end

      S_RRDY: begin
        rd_count_d = rd_count_q + 32'd1;
        oor_hit    = oor_q;
        state_d    = S_RACK;
      end

      S_RACK: begin
        if (bus.finish_read) begin
          state_d   = S_RLAT;
          idx_d     = rd_idx;
          oor_d     = rd_oor;
          lat_cnt_d = rd_lat_init;
        end else if (!bus.read_enable) begin
          state_d = S_IDLE;
        end
      end

      S_WLAT: begin
        if (!bus.write_enable) begin
          state_d = S_IDLE;
        end else if (lat_cnt_q == 16'd0) begin
          state_d = S_WRDY;
        end else begin
          lat_cnt_d = lat_cnt_q - 16'd1;
        end
      end

      S_WRDY: begin
        wr_count_d = wr_count_q + 32'd1;
        oor_hit    = oor_q;
        mem_we     = !oor_q;
        mem_waddr  = idx_q;
        mem_wdata  = bus.write_data;
        state_d    = S_WACK;
      end

      S_WACK: begin
        if (bus.finish_write) begin
          state_d   = S_WLAT;
          idx_d     = wr_idx;
          oor_d     = wr_oor;
          lat_cnt_d = wr_lat_init;
        end else if (!bus.write_enable) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (oor_hit && (oor_count_q != 16'hFFFF)) begin
      oor_count_d = oor_count_q + 16'd1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= 16'd0;
      idx_q       <= '0;
      oor_q       <= 1'b0;
      rd_count_q  <= 32'd0;
      wr_count_q  <= 32'd0;
      oor_count_q <= 16'd0;
      read_data_q <= 32'd0;
      bd_rdata_q  <= 32'd0;
      bd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      idx_q       <= idx_d;
      oor_q       <= oor_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      oor_count_q <= oor_count_d;
      if (rd_load) begin
        read_data_q <= oor_q ? OOR_DATA : mem[idx_q];
      end
      bd_rdata_q  <= mem[bd_addr];
      bd_err_q    <= bd_we && (state_q != S_IDLE);
    end
  end

  // NOTE: the array has no reset; contents must survive reset and map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.read_ready  = {63'd0, state_q == S_RRDY};
  assign bus.write_ready = {63'd0, state_q == S_WRDY};
  assign bus.read_data   = read_data_q;
  assign bd_rdata        = bd_rdata_q;
  assign bd_err          = bd_err_q;
  assign busy            = (state_q != S_IDLE);
  assign rd_count        = rd_count_q;
  assign wr_count        = wr_count_q;
  assign oor_count       = oor_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, multi-cycle corner
// sequences and randomized bursts checked against an array-based memory model.
module tb_mem_responder;

  localparam int          AW       = 13;
  localparam int          RD_LAT   = 2;
  localparam int          WR_LAT   = 1;
  localparam logic [31:0] OOR_DATA = 32'hDEADBEEF;
  localparam int          DEPTH    = 2 ** AW;
`ifdef MEM_RESP_RANDLAT_EN
  localparam int          EXTRA_MAX = 7;
`else
  localparam int          EXTRA_MAX = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_wdata;
  logic [31:0]   bd_rdata;
  logic          bd_err;
  logic          busy;
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
  logic [15:0]   oor_count;

  mem_responder_if bus ();

  mem_responder #(
    .AW(AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .OOR_DATA(OOR_DATA)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .bd_rdata (bd_rdata),
    .bd_err   (bd_err),
    .busy     (busy),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .oor_count(oor_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain word array and access tallies.
  logic [31:0] mdl_mem [DEPTH];
  int          m_rd  = 0;
  int          m_wr  = 0;
  int          m_oor = 0;
  logic [31:0] wbuf [64];
  logic [31:0] last_rd;

  // Protocol monitors.
  int hs_viol     = 0;
  int wr_while_rd = 0;
  int rr_in_reset = 0;
  bit prev_any    = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_any <= 1'b0;
      if (bus.read_ready != 64'd0) rr_in_reset <= rr_in_reset + 1;
    end else begin
      if ((bus.read_ready != 64'd0 && bus.write_ready != 64'd0) ||
          bus.read_ready > 64'd1 || bus.write_ready > 64'd1 ||
          ((bus.read_ready != 64'd0 || bus.write_ready != 64'd0) && prev_any))
        hs_viol <= hs_viol + 1;
      prev_any <= (bus.read_ready != 64'd0 || bus.write_ready != 64'd0);
      if (bus.read_enable && bus.write_ready != 64'd0) wr_while_rd <= wr_while_rd + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int lo_v, input int hi_v, input int lo, input int hi);
    n_tests++;
    if (lo_v < lo || hi_v > hi) begin
      n_fail++;
      $display("FAIL %s: got [%0d..%0d], expected within [%0d..%0d]", name, lo_v, hi_v, lo, hi);
    end
  endtask

  function automatic bit mdl_is_oor(input logic [63:0] a);
    return a >= 64'(DEPTH * 4);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [63:0] a);
    m_rd++;
    if (mdl_is_oor(a)) begin
      if (m_oor < 65535) m_oor++;
      return OOR_DATA;
    end
    return mdl_mem[int'(a / 4)];
  endfunction

  function automatic void mdl_write(input logic [63:0] a, input logic [31:0] d);
    m_wr++;
    if (mdl_is_oor(a)) begin
      if (m_oor < 65535) m_oor++;
    end else begin
      mdl_mem[int'(a / 4)] = d;
    end
  endfunction

  task automatic wait_pulse(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((is_wr ? bus.write_ready : bus.read_ready) != 64'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_burst(input logic [63:0] base, input int n,
                            output int first_lat, output int mn, output int mx, output int got);
    logic [63:0] a;
    logic [31:0] exp;
    int          t0, last;
    bit          ok;
    a = base; got = 0; mn = 1000; mx = 0; first_lat = -1; last = 0;
    @(posedge clk); #1;
    bus.read_addr   = a;
    bus.read_enable = 1'b1;
    t0 = cyc;
    for (int w = 0; w < n; w++) begin
      wait_pulse(1'b0, ok);
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL rd_ready_timeout: no read_ready for addr 0x%0h, expected one within 64 cycles", a);
        break;
      end
      got++;
      if (w == 0) first_lat = cyc - t0;
      else begin
        if (cyc - last - 1 < mn) mn = cyc - last - 1;
        if (cyc - last - 1 > mx) mx = cyc - last - 1;
      end
      last    = cyc;
      exp     = mdl_read(a);
      last_rd = bus.read_data;
      check($sformatf("rd_data@0x%0h", a), 64'(bus.read_data), 64'(exp));
      @(posedge clk); #1;
      if (w < n - 1) begin
        a = a + 64'd4;
        bus.read_addr   = a;
        bus.finish_read = 1'b1;
        @(posedge clk); #1;
        bus.finish_read = 1'b0;
      end
    end
    bus.read_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic write_burst(input logic [63:0] base, input int n,
                             output int mn, output int mx, output int got);
    logic [63:0] a;
    int          last;
    bit          ok;
    a = base; got = 0; mn = 1000; mx = 0; last = 0;
    @(posedge clk); #1;
    bus.write_addr   = a;
    bus.write_data   = wbuf[0];
    bus.write_enable = 1'b1;
    for (int w = 0; w < n; w++) begin
      wait_pulse(1'b1, ok);
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL wr_ready_timeout: no write_ready for addr 0x%0h, expected one within 64 cycles", a);
        break;
      end
      got++;
      if (w > 0) begin
        if (cyc - last - 1 < mn) mn = cyc - last - 1;
        if (cyc - last - 1 > mx) mx = cyc - last - 1;
      end
      last = cyc;
      mdl_write(a, wbuf[w]);
      @(posedge clk); #1;
      if (w < n - 1) begin
        a = a + 64'd4;
        bus.write_addr   = a;
        bus.write_data   = wbuf[w + 1];
        bus.finish_write = 1'b1;
        @(posedge clk); #1;
        bus.finish_write = 1'b0;
      end
    end
    bus.write_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bd_write(input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    bd_addr  = AW'(idx);
    bd_wdata = d;
    bd_we    = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    mdl_mem[idx] = d;
  endtask

  task automatic bd_read(input int idx, output logic [31:0] v);
    @(posedge clk); #1;
    bd_addr = AW'(idx);
    @(posedge clk); #1;
    v = bd_rdata;
  endtask

  typedef struct {
    logic        is_wr;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_oor;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int          fl, mn, mx, got, len;
    bit          ok, do_wr;
    logic [31:0] v;
    logic [63:0] base;

    vecs[0]  = '{1'b0, 64'h8000,                32'h0,         32'hDEADBEEF, 1};
    vecs[1]  = '{1'b1, 64'h8000,                32'h12345678,  32'h0,        2};
    vecs[2]  = '{1'b0, 64'h0,                   32'h0,         32'h00000000, 2};
    vecs[3]  = '{1'b1, 64'h44,                  32'hCAFEF00D,  32'h0,        2};
    vecs[4]  = '{1'b0, 64'h44,                  32'h0,         32'hCAFEF00D, 2};
    vecs[5]  = '{1'b0, 64'hFFFF_FFFF_0000_0000, 32'h0,         32'hDEADBEEF, 3};
    vecs[6]  = '{1'b0, 64'h7FFC,                32'h0,         32'hA5A50001, 3};
    vecs[7]  = '{1'b1, 64'h7FFC,                32'h11112222,  32'h0,        3};
    vecs[8]  = '{1'b0, 64'h7FFC,                32'h0,         32'h11112222, 3};
    vecs[9]  = '{1'b1, 64'h8004,                32'h77777777,  32'h0,        4};
    vecs[10] = '{1'b0, 64'h4,                   32'h0,         32'h00000003, 4};

    bus.read_enable = 1'b0; bus.read_addr = '0; bus.finish_read = 1'b0;
    bus.write_enable = 1'b0; bus.write_addr = '0; bus.write_data = '0; bus.finish_write = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_read_rdy",  bus.read_ready, 64'd0);
    check("rst_write_rdy", bus.write_ready, 64'd0);
    check("rst_read_data", 64'(bus.read_data), 64'd0);
    check("rst_bd_rdata",  64'(bd_rdata), 64'd0);
    check("rst_bd_err",    64'(bd_err), 64'd0);
    check("rst_counts",    {rd_count, wr_count}, 64'd0);
    check("rst_oor",       64'(oor_count), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // 16-word read of preloaded i*3.
    for (int i = 0; i < 16; i++) bd_write(i, 32'(i * 3));
    check("bd_err_idle", 64'(bd_err), 64'd0);
    read_burst(64'h0, 16, fl, mn, mx, got);
    check_range("rd_first_latency", fl, fl, RD_LAT + 1, RD_LAT + 1 + EXTRA_MAX);
    check_range("rd_gap", mn, mx, RD_LAT + 1, RD_LAT + 1 + EXTRA_MAX);
    check("rd_burst_pulses", 64'(got), 64'd16);
    check("rd_count_16", 64'(rd_count), 64'd16);
    check("idle_after_rd", 64'(busy), 64'd0);

    // 8-word write at 0x40.
    for (int k = 0; k < 8; k++) wbuf[k] = 32'(100 + k);
    write_burst(64'h40, 8, mn, mx, got);
    check("wr_burst_pulses", 64'(got), 64'd8);
    check_range("wr_gap", mn, mx, WR_LAT + 1, WR_LAT + 1 + EXTRA_MAX);
    check("wr_count_8", 64'(wr_count), 64'd8);
    for (int k = 0; k < 8; k++) begin
      bd_read(16 + k, v);
      check($sformatf("bd_rdata_idx%0d", 16 + k), 64'(v), 64'(100 + k));
    end

    // Directed single accesses: range boundaries, OOR, read-after-write.
    bd_write(DEPTH - 1, 32'hA5A50001);
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        wbuf[0] = vecs[i].wdata;
        write_burst(vecs[i].addr, 1, mn, mx, got);
      end else begin
        read_burst(vecs[i].addr, 1, fl, mn, mx, got);
        check($sformatf("vec%0d_rdata", i), 64'(last_rd), 64'(vecs[i].exp_rdata));
      end
      check($sformatf("vec%0d_oor", i), 64'(oor_count), 64'(vecs[i].exp_oor));
    end

    // Simultaneous enables: read is serviced first, write waits for read_enable to fall.
    wbuf[0] = 32'h5EED0001;
    @(posedge clk); #1;
    bus.read_addr = 64'h0; bus.read_enable = 1'b1;
    bus.write_addr = 64'h80; bus.write_data = wbuf[0]; bus.write_enable = 1'b1;
    read_burst(64'h0, 2, fl, mn, mx, got);
    check("simul_rd_pulses", 64'(got), 64'd2);
    write_burst(64'h80, 1, mn, mx, got);
    check("simul_wr_pulses", 64'(got), 64'd1);
    check("simul_wr_while_rd", 64'(wr_while_rd), 64'd0);
    bd_read(32, v);
    check("simul_wr_data", 64'(v), 64'(32'h5EED0001));

    // Backdoor write while a read is in flight is dropped.
    @(posedge clk); #1;
    bus.read_addr = 64'd20; bus.read_enable = 1'b1;
    @(posedge clk); #1;
    bd_addr = AW'(5); bd_wdata = 32'hBAD0BAD0; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    check("bd_err_pulse", 64'(bd_err), 64'd1);
    wait_pulse(1'b0, ok);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL bd_busy_rd_timeout: no read_ready, expected one within 64 cycles");
    end else begin
      check("bd_busy_rd_data", 64'(bus.read_data), 64'(mdl_read(64'd20)));
    end
    @(posedge clk); #1;
    bus.read_enable = 1'b0;
    check("bd_err_one_cycle", 64'(bd_err), 64'd0);
    bd_read(5, v);
    check("bd_dropped_word", 64'(v), 64'(mdl_mem[5]));

    // Reset in the middle of read latency.
    @(posedge clk); #1;
    bus.read_addr = 64'h10; bus.read_enable = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_counts", {rd_count, wr_count}, 64'd0);
    check("mid_rst_oor", 64'(oor_count), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.read_enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    m_rd = 0; m_wr = 0; m_oor = 0;
    check("mid_rst_no_ready", 64'(rr_in_reset), 64'd0);
    for (int i = 0; i < 16; i++) begin
      bd_read(i, v);
      check($sformatf("mem_kept_idx%0d", i), 64'(v), 64'(mdl_mem[i]));
    end

    // Randomized bursts against the model.
    for (int i = 0; i < 256; i++) bd_write(i, $urandom);
    for (int t = 0; t < 40; t++) begin
      len   = int'($urandom_range(1, 8));
      do_wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) base = 64'(DEPTH * 4) + 64'($urandom_range(0, 63) * 4);
      else                           base = 64'($urandom_range(0, 200) * 4);
      if (do_wr) begin
        for (int k = 0; k < len; k++) wbuf[k] = $urandom;
        write_burst(base, len, mn, mx, got);
        if (len > 1) check_range("rand_wr_gap", mn, mx, WR_LAT + 1, WR_LAT + 1 + EXTRA_MAX);
      end else begin
        read_burst(base, len, fl, mn, mx, got);
        if (len > 1) check_range("rand_rd_gap", mn, mx, RD_LAT + 1, RD_LAT + 1 + EXTRA_MAX);
      end
    end

    // 64-word write-then-read round trip.
    for (int k = 0; k < 64; k++) wbuf[k] = $urandom;
    write_burst(64'd1200, 64, mn, mx, got);
    check_range("rt_wr_gap", mn, mx, WR_LAT + 1, WR_LAT + 1 + EXTRA_MAX);
    read_burst(64'd1200, 64, fl, mn, mx, got);
    check_range("rt_rd_gap", mn, mx, RD_LAT + 1, RD_LAT + 1 + EXTRA_MAX);
    check("rt_rd_pulses", 64'(got), 64'd64);
`ifdef MEM_RESP_RANDLAT_EN
    check("rt_gap_varies", 64'(mx > mn), 64'd1);
`endif

    check("final_rd_count", 64'(rd_count), 64'(m_rd));
    check("final_wr_count", 64'(wr_count), 64'(m_wr));
    check("final_oor_count", 64'(oor_count), 64'(m_oor));
    check("handshake_rules", 64'(hs_viol), 64'd0);
    check("final_wr_while_rd", 64'(wr_while_rd), 64'd0);
    check("final_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
